debounce_filter: RTL and testbench

- Debounces one bouncy single-bit input, e.g. a mechanical switch or button, into a clean level.
- The output changes state only after the input has held the opposite level for DEBOUNCE_LIMIT consecutive clock samples.
- Sits between a board-level pin and control logic. It also provides single-cycle edge pulses so downstream logic does not need its own edge detector.

---
 rtl/debounce_filter.sv | 127 ++++++++++++
 tb/tb_debounce_filter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
//
// Purpose:
//   Turns one bouncy single-bit input, such as a mechanical switch, into a
//   clean level. The filtered output changes only after the input has held
//   the opposite level for DEBOUNCE_LIMIT consecutive clock samples. Any
//   sample that matches the current output level restarts the count.
//   The block also emits single-cycle rise/fall pulses, so downstream logic
//   needs no edge detector of its own.
//
// Parameters:
//   DEBOUNCE_LIMIT - consecutive differing samples needed to flip the output
//                    (>= 1; smaller values stop elaboration).
//   RESET_VALUE    - level of o_debounced during and right after reset.
//
// Optional feature macro:
//   DEBOUNCE_FILTER_SYNC_EN - when defined, i_bouncy first passes through a
//   2-flop synchronizer (reset to RESET_VALUE), which makes the block safe
//   for fully asynchronous pins. This adds two edges of latency. When it is
//   not defined, i_bouncy must already be synchronous to i_clk.
//
// Ports:
//   i_clk       - sole clock; all state updates on its rising edge
//   i_rst_n     - asynchronous active-low reset
//   i_bouncy    - raw, possibly glitching input
//   o_debounced - filtered level, driven straight from a flop
//   o_rise      - one-cycle pulse when o_debounced goes 0->1
//   o_fall      - one-cycle pulse when o_debounced goes 1->0
//
// Handshake: none. Every cycle is a valid output cycle. o_rise/o_fall are
//   high during the first cycle in which o_debounced shows its new level.
// -----------------------------------------------------------------------------
module debounce_filter #(
    parameter int   DEBOUNCE_LIMIT = 250000,
    parameter logic RESET_VALUE    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_bouncy,
    output logic o_debounced,
    output logic o_rise,
    output logic o_fall
);

    // Stop elaboration on an illegal limit.
    if (DEBOUNCE_LIMIT < 1) begin : g_bad_limit
        $error("debounce_filter: DEBOUNCE_LIMIT must be >= 1");
    end

    localparam int              CNT_W    = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(DEBOUNCE_LIMIT - 1);

    // Filter sample.
    logic sample;

`ifdef DEBOUNCE_FILTER_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = i_bouncy;
        sync2_d = sync1_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sample = sync2_q;
`else
    assign sample = i_bouncy;
`endif

    // Filter state.
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (sample != state_q) begin
            // The ">=" keeps the counter bounded even if it were ever
            // corrupted; in normal operation it reaches LIMIT_M1 exactly.
            if (cnt_q >= LIMIT_M1) begin
                state_d = sample;
                cnt_d   = '0;
                rise_d  = sample;
                fall_d  = ~sample;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // When the sample matches the current state, the count restarts
        // (cnt_d defaults to 0). That is what rejects glitches.
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RESET_VALUE;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_debounced = state_q;
    assign o_rise      = rise_q;
    assign o_fall      = fall_q;

endmodule

// File: tb/tb_debounce_filter.sv
// -----------------------------------------------------------------------------
// tb_debounce_filter
//
// Drives debounce_filter (DEBOUNCE_LIMIT=4, RESET_VALUE=0) with directed,
// hand-computed segments. Each segment starts right after reset.
//
// The driver sets i_bouncy on the falling edge. At the same time it pushes
// the {o_debounced, o_rise, o_fall} value expected after the next rising
// edge into exp_q. A monitor samples the outputs 1 ns after each rising edge
// and, whenever an expectation is queued, pops it and compares.
//
// With DEBOUNCE_FILTER_SYNC_EN defined, the filter sees the input two edges
// later, starting from reset-level samples. The expected stream is then the
// same table shifted by two cycles, with reset-level outputs filling the gap.
// -----------------------------------------------------------------------------
module tb_debounce_filter;

    localparam int LIMIT = 4;
`ifdef DEBOUNCE_FILTER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic bouncy;
    logic deb, rise, fall;

    always #5 clk = ~clk;

    debounce_filter #(
        .DEBOUNCE_LIMIT(LIMIT),
        .RESET_VALUE   (1'b0)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_bouncy   (bouncy),
        .o_debounced(deb),
        .o_rise     (rise),
        .o_fall     (fall)
    );

    // ---------------- scoreboard ----------------
    logic [2:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         edge_n = 0;

    always @(posedge clk) begin
        #1;
        edge_n++;
        if (exp_q.size() > 0) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            total++;
            if ({deb, rise, fall} !== e) begin
                bad++;
                $display("FAIL seq_edge_%0d got {deb,rise,fall}=%b expected=%b",
                         edge_n, {deb, rise, fall}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Bit n-1 of each vector is the first edge of the segment.
    task automatic run_seg(input int n, input logic [31:0] ins,
                           input logic [31:0] e_deb, input logic [31:0] e_rise,
                           input logic [31:0] e_fall);
        for (int i = 0; i < n; i++) begin
            int j;
            @(negedge clk);
            bouncy = ins[n-1-i];
            if (i < LAT) begin
                exp_q.push_back(3'b000);
            end else begin
                j = n - 1 - (i - LAT);
                exp_q.push_back({e_deb[j], e_rise[j], e_fall[j]});
            end
        end
        @(negedge clk); // the last expectation is checked by now
    endtask

    task automatic check_now(input string name, input logic [2:0] e);
        total++;
        if ({deb, rise, fall} !== e) begin
            bad++;
            $display("FAIL %s got {deb,rise,fall}=%b expected=%b",
                     name, {deb, rise, fall}, e);
        end
    endtask

    // Asserts reset in the middle of the low phase with i_bouncy high,
    // checks the outputs before any edge, holds reset across an edge,
    // then releases it on a falling edge.
    task automatic mid_reset(input string name);
        #2;
        bouncy = 1'b1;
        rst_n  = 1'b0;
        #1;
        check_now({name, "_async"}, 3'b000);
        @(posedge clk);
        #1;
        check_now({name, "_held"}, 3'b000);
        @(negedge clk);
        bouncy = 1'b0;
        rst_n  = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wait_cyc;
        rst_n  = 1'b0;
        bouncy = 1'b0;
        #1;
        check_now("reset_state", 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean rise (edge 4), then clean fall (edge 10).
        run_seg(11, 32'b11111100000, 32'b00011111100,
                32'b00010000000, 32'b00000000010);
        mid_reset("reset_a");

        // Glitch: 1,0,1,1,1,1,1 rises only at edge 6.
        run_seg(7, 32'b1011111, 32'b0000011, 32'b0000010, 32'b0);
        mid_reset("reset_b");

        // Short pulse of 3 edges: nothing changes.
        run_seg(7, 32'b1110000, 32'b0, 32'b0, 32'b0);
        mid_reset("reset_c");

        // Rise, then two fall samples, then reset while still high.
        run_seg(6, 32'b111100, 32'b000111, 32'b000100, 32'b0);
        mid_reset("reset_mid_count");

        // After reset the count starts from zero: the rise needs 4 edges.
        run_seg(5, 32'b11110, 32'b00011, 32'b00010, 32'b0);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 100) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain got pending=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
